statistics_counters: RTL and testbench

//  Bank of event counters for switch statistics (per-port/per-flow packet and byte counts).

---
 rtl/statistics_counters.sv | 106 ++++++++++
 tb/tb_statistics_counters.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/statistics_counters.sv
// Bank of RAM-backed event counters with a three-stage read-modify-write increment
// pipeline, per-entry valid bits for instant clear, and a registered host read port.
module statistics_counters #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_COUNTERS = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int IDX_W = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(NUM_COUNTERS);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wrap_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    return a + b;
  endfunction

  logic [DATA_WIDTH-1:0]   r_mem [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] r_valid;

  logic                  r_vld_p0;
  logic [IDX_W-1:0]      r_addr_p0;
  logic [DATA_WIDTH-1:0] r_din_p0;

  logic                  r_vld_p1;
  logic                  r_fwd_p1;
  logic                  r_vbit_p1;
  logic [IDX_W-1:0]      r_addr_p1;
  logic [DATA_WIDTH-1:0] r_din_p1;
  logic [DATA_WIDTH-1:0] r_ram_p1;
  logic [DATA_WIDTH-1:0] r_fwd_data_p1;

  logic [DATA_WIDTH-1:0] w_base_p1;
  logic [DATA_WIDTH-1:0] w_sum_p1;

  logic                  r_rd_ok;
  logic [DATA_WIDTH-1:0] r_rd_ram;

  // ---- S0: accept and register the request ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_vld_p0 <= 1'b0;
    else        r_vld_p0 <= we && in_range(addr);
  end

  always_ff @(posedge clk) begin
    r_addr_p0 <= addr[IDX_W-1:0];
    r_din_p0  <= din;
  end

  // ---- S1: RAM read, with the S2 write forwarded when addresses collide ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p1 <= 1'b0;
      r_fwd_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      r_fwd_p1 <= r_vld_p1 && (r_addr_p1 == r_addr_p0);
    end
  end

  always_ff @(posedge clk) begin
    r_ram_p1      <= r_mem[r_addr_p0];
    r_vbit_p1     <= r_valid[r_addr_p0];
    r_fwd_data_p1 <= w_sum_p1;
    r_addr_p1     <= r_addr_p0;
    r_din_p1      <= r_din_p0;
  end

  assign w_base_p1 = r_fwd_p1  ? r_fwd_data_p1 :
                     r_vbit_p1 ? r_ram_p1      : '0;
  assign w_sum_p1  = wrap_add(w_base_p1, r_din_p1);

  // ---- S2: commit sum and mark the entry valid ----
  always_ff @(posedge clk) begin
    if (r_vld_p1) r_mem[r_addr_p1] <= w_sum_p1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_valid <= '0;
    else if (r_vld_p1) r_valid[r_addr_p1] <= 1'b1;
  end

  // ---- Host read port: committed state only, no pipeline forwarding ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rd_ok <= 1'b0;
    else        r_rd_ok <= in_range(raddr) && r_valid[raddr[IDX_W-1:0]];
  end

  always_ff @(posedge clk) begin
    r_rd_ram <= r_mem[raddr[IDX_W-1:0]];
  end

  assign rdata = r_rd_ok ? r_rd_ram : '0;

endmodule

// File: tb/tb_statistics_counters.sv
// Scoreboard bench for statistics_counters: a reference counter array with the
// increment-to-read visibility delay predicts every host read.
module tb_statistics_counters;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int N  = 1024;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] addr  = '0;
  logic          we    = 1'b0;
  logic [DW-1:0] din   = '0;
  logic [AW-1:0] raddr = '0;
  logic [DW-1:0] rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] model [N];
  logic          pend_we   [2];
  logic [9:0]    pend_addr [2];
  logic [DW-1:0] pend_din  [2];
  logic [DW-1:0] exp_q [$];
  string         tag_q [$];

  statistics_counters #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .NUM_COUNTERS(N)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .raddr(raddr),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, model commits at posedge, read compared at next negedge.
  // A write committed by the DUT at edge E corresponds to pend slot 1 at that edge.
  task automatic step(input logic i_we, input logic [AW-1:0] i_addr, input logic [DW-1:0] i_din,
                      input logic i_rd, input logic [AW-1:0] i_raddr, input string tag);
    logic [DW-1:0] exp;
    we    = i_we;
    addr  = i_addr;
    din   = i_din;
    raddr = i_raddr;
    if (i_rd) begin
      exp = (int'(i_raddr) < N) ? model[i_raddr[9:0]] : '0;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(posedge clk);
    if (pend_we[1]) model[pend_addr[1]] = model[pend_addr[1]] + pend_din[1];
    pend_we[1]   = pend_we[0];
    pend_addr[1] = pend_addr[0];
    pend_din[1]  = pend_din[0];
    pend_we[0]   = i_we && (int'(i_addr) < N);
    pend_addr[0] = i_addr[9:0];
    pend_din[0]  = i_din;
    @(negedge clk);
    if (i_rd) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: scoreboard empty", tag);
      end else begin
        check_eq(tag_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, "idle");
  endtask

  task automatic rd(input logic [AW-1:0] a, input string tag);
    step(1'b0, '0, '0, 1'b1, a, tag);
  endtask

  // Asynchronous reset pulse; inputs may keep strobing to show nothing is accepted meanwhile.
  task automatic do_reset(input logic hold_we);
    reset = 1'b0;
    we    = hold_we;
    addr  = 16'd42;
    din   = 32'd1;
    for (int i = 0; i < N; i++) model[i] = '0;
    for (int i = 0; i < 2; i++) begin
      pend_we[i]   = 1'b0;
      pend_addr[i] = '0;
      pend_din[i]  = '0;
    end
    exp_q.delete();
    tag_q.delete();
    #1;
    check_eq("reset_rdata", rdata, '0);
    repeat (2) @(negedge clk);
    check_eq("reset_rdata_held", rdata, '0);
    reset = 1'b1;
    we    = 1'b0;
  endtask

  initial begin
    #2;
    do_reset(1'b0);

    // Reset state reads
    rd(16'd0,    "t1_rd0");
    rd(16'd42,   "t1_rd42");
    rd(16'd1023, "t1_rd1023");
    rd(16'd1024, "t1_rd1024");

    // Out-of-range increments are dropped
    for (int i = 0; i < 100; i++) step((i % 2) == 0, 16'd1024, 32'd1, 1'b0, '0, "t2");
    idle(3);
    for (int i = 0; i < N; i++) rd(16'(i), "t2_rdall");

    // Toggling strobe on one counter, then reads interleaved with continued toggling
    for (int i = 0; i < 40; i++) step((i % 2) == 0, 16'd42, 32'd1, 1'b0, '0, "t3");
    idle(3);
    rd(16'd42, "t3_rd42");
    for (int i = 0; i < 12; i++) step((i % 2) == 0, 16'd42, 32'd1, 1'b1, 16'd42, "t3_grow");

    // Back-to-back same address, then alternating addresses
    for (int i = 0; i < 16; i++) step(1'b1, 16'd7, 32'd3, 1'b0, '0, "t4");
    idle(3);
    rd(16'd7, "t4_rd7");
    for (int i = 0; i < 10; i++) step(1'b1, (i % 2) ? 16'd6 : 16'd5, 32'd1, 1'b0, '0, "t4b");
    idle(3);
    rd(16'd5, "t4_rd5");
    rd(16'd6, "t4_rd6");

    // Modulo wrap
    step(1'b1, 16'd9, 32'hFFFF_FFFE, 1'b0, '0, "t5");
    step(1'b1, 16'd9, 32'd3, 1'b0, '0, "t5");
    idle(3);
    rd(16'd9, "t5_rd9");

    // Same-cycle increment and read, plus reads at each latency after the strobe
    step(1'b1, 16'd100, 32'd5, 1'b1, 16'd100, "same_cycle");
    rd(16'd100, "lat1");
    rd(16'd100, "lat2");
    rd(16'd100, "lat3");

    // Reset mid-stream discards everything in flight
    for (int i = 0; i < 6; i++) step(1'b1, 16'd42, 32'd1, 1'b0, '0, "t6_pre");
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 16'd42, 32'd1, 1'b1, 16'd42, "t6_post");
    idle(3);
    rd(16'd42, "t6_rd42");
    rd(16'd7,  "t6_rd7");
    rd(16'd9,  "t6_rd9");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
